// File: rtl/ervp_seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed/unsigned operands,
// divide-by-zero flag, valid/ready request and response handshakes.
module ervp_seq_divider #(
    parameter int unsigned BW_DIVIDEND = 32,
    parameter int unsigned BW_DIVISOR  = 32
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_signed,
    input  logic [BW_DIVIDEND-1:0] req_dividend,
    input  logic [BW_DIVISOR-1:0]  req_divisor,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BW_DIVIDEND-1:0] rsp_quotient,
    output logic [BW_DIVISOR-1:0]  rsp_remainder,
    output logic                   rsp_div_by_zero
);

    localparam int unsigned CNT_W = $clog2(BW_DIVIDEND + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [BW_DIVIDEND-1:0] r_quo;
    logic [BW_DIVISOR-1:0]  r_div;
    logic [BW_DIVISOR-1:0]  r_rem;
    logic [CNT_W-1:0]       r_cnt;
    logic [BW_DIVIDEND-1:0] r_quotient;
    logic [BW_DIVISOR-1:0]  r_remainder;
    logic                   r_dz;

    logic                   w_div_zero;
    logic                   w_dvd_neg;
    logic                   w_dvs_neg;
    logic [BW_DIVIDEND-1:0] w_dvd_mag;
    logic [BW_DIVISOR-1:0]  w_dvs_mag;
    logic [BW_DIVISOR:0]    w_rem_shift;
    logic [BW_DIVISOR:0]    w_rem_diff;
    logic                   w_qbit;
    logic                   w_last_bit;

    assign w_div_zero  = (req_divisor == '0);
    assign w_dvd_neg   = req_signed & req_dividend[BW_DIVIDEND-1];
    assign w_dvs_neg   = req_signed & req_divisor[BW_DIVISOR-1];
    assign w_dvd_mag   = w_dvd_neg ? -req_dividend : req_dividend;
    assign w_dvs_mag   = w_dvs_neg ? -req_divisor  : req_divisor;

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_rem_shift = {r_rem, r_quo[BW_DIVIDEND-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_div};
    assign w_qbit      = ~w_rem_diff[BW_DIVISOR];
    assign w_last_bit  = (r_cnt == CNT_W'(BW_DIVIDEND - 1));

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_state_next = w_div_zero ? S_DONE : S_BUSY;
            S_BUSY: if (w_last_bit) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_DONE;
            S_DONE: if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:  req_ready = 1'b1;
            S_DONE:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quo       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_quo   <= w_dvd_mag;
                        r_div   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (w_div_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= req_dividend[BW_DIVISOR-1:0];
                            r_dz        <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_qbit ? w_rem_diff[BW_DIVISOR-1:0] : w_rem_shift[BW_DIVISOR-1:0];
                    r_quo <= {r_quo[BW_DIVIDEND-2:0], w_qbit};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    // Negating a zero magnitude stays zero, so sign rules need no special case.
                    r_quotient  <= r_neg_q ? -r_quo : r_quo;
                    r_remainder <= r_neg_r ? -r_rem : r_rem;
                    r_dz        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_quotient    = r_quotient;
    assign rsp_remainder   = r_remainder;
    assign rsp_div_by_zero = r_dz;

endmodule

// File: tb/tb_ervp_seq_divider.sv
// Scoreboard bench for ervp_seq_divider at default 32/32 widths.
module tb_ervp_seq_divider;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic        rsp_div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ervp_seq_divider #(.BW_DIVIDEND(32), .BW_DIVISOR(32)) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_signed      (req_signed),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_quotient    (rsp_quotient),
        .rsp_remainder   (rsp_remainder),
        .rsp_div_by_zero (rsp_div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference: SV integer division truncates toward zero, % follows dividend sign.
    function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            e.q = 32'(sa / sb); e.r = 32'(sa % sb); e.dz = 1'b0; e.lat = 34;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 34;
        end
        return e;
    endfunction

    // Latency counts edges with the accepting edge as edge 1.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        req_valid = 1'b1; req_signed = sg; req_dividend = a; req_divisor = b;
        sb_q.push_back(model(sg, a, b));
        @(posedge clk); #1;
        req_valid = 1'b0; req_signed = ~sg; req_dividend = $urandom; req_divisor = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check("latency", 64'(lat), 64'(e.lat));
        check("quotient", 64'(rsp_quotient), 64'(e.q));
        check("remainder", 64'(rsp_remainder), 64'(e.r));
        check("div_by_zero", 64'(rsp_div_by_zero), 64'(e.dz));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_quotient", 64'(rsp_quotient), 64'(e.q));
            check("hold_remainder", 64'(rsp_remainder), 64'(e.r));
            check("hold_dz", 64'(rsp_div_by_zero), 64'(e.dz));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("ret_req_ready", 64'(req_ready), 64'd1);
        check("ret_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rstnn = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
        req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_quotient", 64'(rsp_quotient), 64'd0);
        check("rst_remainder", 64'(rsp_remainder), 64'd0);
        check("rst_dz", 64'(rsp_div_by_zero), 64'd0);
        rstnn = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(1'b0, 32'd5, 32'd0, 0);
        run_op(1'b1, 32'd5, 32'd0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 10);
        run_op(1'b1, 32'h8000_0000, 32'd0, 2);

        // Abort mid-operation: reset during BUSY cycle 10 leaves no result behind.
        @(negedge clk);
        req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("busy_req_ready", 64'(req_ready), 64'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rstnn = 1'b0;
        @(posedge clk); #1;
        rstnn = 1'b1;
        check("abort_req_ready", 64'(req_ready), 64'd1);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_quotient", 64'(rsp_quotient), 64'd0);
        check("abort_remainder", 64'(rsp_remainder), 64'd0);
        check("abort_dz", 64'(rsp_div_by_zero), 64'd0);
        run_op(1'b0, 32'd100, 32'd7, 0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_op(1'(i % 2), a, b, i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
